// File: rtl/fifo_cdcc_pkg.sv
// Shared constants for the clock-domain-crossing FIFO (read and write controllers).
package fifo_cdcc_pkg;

  localparam int FIFO_PTR_BITS = 10;
  localparam int FIFO_DEPTH    = 1 << FIFO_PTR_BITS;
  localparam int FIFO_DATA_W   = 32;
  localparam int RD_BUF_DEPTH  = 2;
  localparam int RD_BUF_CNT_W  = $clog2(RD_BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry ordered output buffer. Entry 0 is the head and is a flop, so the
// consumer-facing data never sees a combinational path from the push side.
module fifo_rd_skid_buf
  import fifo_cdcc_pkg::*;
#(
  parameter int W = FIFO_DATA_W
) (
  input  logic                    gclk,
  input  logic                    grst_n,
  input  logic                    i_push,
  input  logic [W-1:0]            i_din,
  input  logic                    i_pop,
  output logic [W-1:0]            o_dout,
  output logic [RD_BUF_CNT_W-1:0] o_cnt
);

  logic [RD_BUF_DEPTH-1:0][W-1:0] r_mem;
  logic [RD_BUF_CNT_W-1:0]        r_cnt;

  // Push writes the tail, pop shifts entry 1 into the head; both at once keep
  // the count and keep the order (head goes out, new word lands behind the rest).
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_mem <= '0;
      r_cnt <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          r_mem[r_cnt[0]] <= i_din;
          r_cnt           <= r_cnt + 1'b1;
        end
        2'b01: begin
          r_mem[0] <= r_mem[1];
          r_cnt    <= r_cnt - 1'b1;
        end
        2'b11: begin
          if (r_cnt == RD_BUF_CNT_W'(1)) begin
            r_mem[0] <= i_din;
          end else begin
            r_mem[0] <= r_mem[1];
            r_mem[1] <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dout = r_mem[0];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO: issues RAM reads from the local read
// pointer and presents the words on an AXI-stream style valid/ready port.
// Optional macro FIFO_RD_FILL_LEVEL_EN adds a registered o_fill_level output.
module fifo_read_ctrl
  import fifo_cdcc_pkg::*;
#(
  parameter int INT_FIFO_PTR_BITS_CNT = FIFO_PTR_BITS,
  parameter int INT_DATA_WIDTH        = FIFO_DATA_W
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  input  logic [INT_FIFO_PTR_BITS_CNT-1:0] i_wr_ptr,
  output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_rd_ptr,
  output logic                             o_ram_rd_en,
  output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_ram_rd_addr,
  input  logic [INT_DATA_WIDTH-1:0]        i_ram_rd_data,
  output logic                             o_valid,
  output logic [INT_DATA_WIDTH-1:0]        o_data,
`ifdef FIFO_RD_FILL_LEVEL_EN
  output logic [INT_FIFO_PTR_BITS_CNT:0]   o_fill_level,
`endif
  input  logic                             i_ready
);

  localparam int N = INT_FIFO_PTR_BITS_CNT;

  logic [N-1:0]            r_rd_ptr;
  logic                    r_inflight;
  logic [RD_BUF_CNT_W-1:0] w_cnt;
  logic                    w_empty;
  logic                    w_pop;
  logic [RD_BUF_CNT_W:0]   w_occ;
  logic                    w_rd_en;

  assign w_empty = (i_wr_ptr == r_rd_ptr);
  assign w_pop   = o_valid & i_ready;
  // Slots committed after this edge; pop implies w_cnt >= 1 so no underflow.
  assign w_occ   = {1'b0, w_cnt} + (RD_BUF_CNT_W + 1)'(r_inflight)
                 - (RD_BUF_CNT_W + 1)'(w_pop);
  // Gated by reset so no strobe escapes while the block is held in reset.
  assign w_rd_en = rd_rst_n & ~w_empty & (w_occ < (RD_BUF_CNT_W + 1)'(RD_BUF_DEPTH));

  // Read pointer advances on every strobe; inflight marks the data due next cycle.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  fifo_rd_skid_buf #(.W(INT_DATA_WIDTH)) u_buf (
    .gclk   (rd_clk),
    .grst_n (rd_rst_n),
    .i_push (r_inflight),
    .i_din  (i_ram_rd_data),
    .i_pop  (w_pop),
    .o_dout (o_data),
    .o_cnt  (w_cnt)
  );

  assign o_valid       = (w_cnt != '0);
  assign o_rd_ptr      = r_rd_ptr;
  assign o_ram_rd_en   = w_rd_en;
  assign o_ram_rd_addr = r_rd_ptr;

`ifdef FIFO_RD_FILL_LEVEL_EN
  logic [N-1:0] w_ram_words;
  logic [N:0]   r_fill;

  assign w_ram_words = i_wr_ptr - r_rd_ptr;

  // Words still in RAM plus words already pulled into the read side.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) r_fill <= '0;
    else           r_fill <= {1'b0, w_ram_words} + (N + 1)'(w_cnt) + (N + 1)'(r_inflight);
  end

  assign o_fill_level = r_fill;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: the write side is modelled as a RAM plus
// a queue of words in write order; a monitor pops and compares every beat.
module tb_fifo_read_ctrl;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 1 << N;

  logic         rd_clk = 1'b0;
  logic         rd_rst_n;
  logic [N-1:0] i_wr_ptr;
  logic [N-1:0] o_rd_ptr;
  logic         o_ram_rd_en;
  logic [N-1:0] o_ram_rd_addr;
  logic [W-1:0] i_ram_rd_data;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic         i_ready;
`ifdef FIFO_RD_FILL_LEVEL_EN
  logic [N:0]   o_fill_level;
`endif

  fifo_read_ctrl #(.INT_FIFO_PTR_BITS_CNT(N), .INT_DATA_WIDTH(W)) dut (
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .i_wr_ptr      (i_wr_ptr),
    .o_rd_ptr      (o_rd_ptr),
    .o_ram_rd_en   (o_ram_rd_en),
    .o_ram_rd_addr (o_ram_rd_addr),
    .i_ram_rd_data (i_ram_rd_data),
    .o_valid       (o_valid),
    .o_data        (o_data),
`ifdef FIFO_RD_FILL_LEVEL_EN
    .o_fill_level  (o_fill_level),
`endif
    .i_ready       (i_ready)
  );

  always #5 rd_clk = ~rd_clk;

  logic [W-1:0] ram [D];
  logic [W-1:0] exp_q [$];
  logic [N-1:0] addr_log [$];
  int           n_chk  = 0;
  int           n_pass = 0;
  int           strobes = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Synchronous RAM model: data appears one cycle after the strobe.
  always @(posedge rd_clk) begin
    if (rd_rst_n && o_ram_rd_en) begin
      i_ram_rd_data <= ram[o_ram_rd_addr];
      strobes++;
      addr_log.push_back(o_ram_rd_addr);
      chk("read_when_empty", 64'(o_ram_rd_addr == i_wr_ptr), 64'd0);
    end
  end

  // Monitor: every accepted beat must be the next word written; a stalled beat must hold.
  always @(negedge rd_clk) begin
    if (!rd_rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(o_valid), 64'd1);
        chk("hold_data", 64'(o_data), 64'(hold_d));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("spurious_beat", 64'(o_valid), 64'd0);
        else chk("beat_data", 64'(o_data), 64'(exp_q.pop_front()));
      end
      hold_v = o_valid && !i_ready;
      hold_d = o_data;
    end
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic write_words(input int k);
    for (int i = 0; i < k; i++) begin
      logic [W-1:0] d;
      d = $urandom;
      ram[i_wr_ptr] = d;
      exp_q.push_back(d);
      i_wr_ptr = i_wr_ptr + 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) step();
  endtask

  // Waits (bounded) for the first beat, then counts back-to-back valid cycles.
  task automatic count_beats(output int n);
    n = 0;
    for (int i = 0; i < 10 && !o_valid; i++) step();
    while (o_valid && n < 50) begin
      n++;
      step();
    end
  endtask

  initial begin
    int lat, nb, s0;
    logic [N-1:0] base;
    rd_rst_n = 1'b0;
    i_wr_ptr = '0;
    i_ready  = 1'b1;
    i_ram_rd_data = '0;
    for (int i = 0; i < D; i++) ram[i] = '0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_rd_en", 64'(o_ram_rd_en), 64'd0);
    chk("rst_rd_ptr", 64'(o_rd_ptr), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    repeat (3) step();
    rd_rst_n = 1'b1;

    // Idle with an empty FIFO.
    nb = 0;
    repeat (10) begin
      step();
      if (o_ram_rd_en || o_valid || o_rd_ptr != 0) nb++;
    end
    chk("idle_activity", 64'(nb), 64'd0);

    // Single word: strobe in the same cycle, valid two edges later.
    write_words(1);
    #1;
    chk("first_rd_en", 64'(o_ram_rd_en), 64'd1);
    chk("first_rd_addr", 64'(o_ram_rd_addr), 64'd0);
    lat = 0;
    while (!o_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("first_latency", 64'(lat), 64'd2);
    drain();
    chk("rd_ptr_after_1", 64'(o_rd_ptr), 64'(i_wr_ptr));

    // Eight-word burst at full rate.
    write_words(8);
    count_beats(nb);
    chk("burst8_beats", 64'(nb), 64'd8);
    chk("burst8_valid_after", 64'(o_valid), 64'd0);
    chk("burst8_rd_ptr", 64'(o_rd_ptr), 64'(i_wr_ptr));

    // Stalled consumer: only two reads go out, head held, then gapless drain.
    i_ready = 1'b0;
    s0 = strobes;
    write_words(5);
    repeat (10) step();
    chk("stall_strobes", 64'(strobes - s0), 64'd2);
    chk("stall_valid", 64'(o_valid), 64'd1);
    chk("stall_head", 64'(o_data), 64'(exp_q[0]));
`ifdef FIFO_RD_FILL_LEVEL_EN
    chk("fill_level", 64'(o_fill_level), 64'(exp_q.size()));
`endif
    i_ready = 1'b1;
    count_beats(nb);
    chk("stall_drain_beats", 64'(nb), 64'd5);
    drain();

    // Pointer wrap: four reads crossing the top of the address space.
    base = i_wr_ptr;
    addr_log.delete();
    write_words(4);
    drain();
    chk("wrap_count", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("wrap_addr", 64'(addr_log[i]), 64'(N'(base + N'(i))));
    chk("wrap_rd_ptr", 64'(o_rd_ptr), 64'(i_wr_ptr));

    // Random writes and back-pressure; RAM never overfilled.
    repeat (400) begin
      int k;
      i_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 4);
        if (exp_q.size() + k <= D - 1) write_words(k);
      end
      step();
    end
    i_ready = 1'b1;
    drain();
    chk("rand_rd_ptr", 64'(o_rd_ptr), 64'(i_wr_ptr));
    chk("rand_idle_valid", 64'(o_valid), 64'd0);

    // Reset in the middle of a stalled burst.
    i_ready = 1'b0;
    write_words(6);
    repeat (8) step();
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    rd_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_rd_ptr", 64'(o_rd_ptr), 64'd0);
    chk("midrst_rd_en", 64'(o_ram_rd_en), 64'd0);
    chk("midrst_data", 64'(o_data), 64'd0);
    exp_q.delete();
    i_wr_ptr = '0;
    repeat (2) step();
    rd_rst_n = 1'b1;
    i_ready  = 1'b1;
    nb = 0;
    repeat (10) begin
      step();
      if (o_valid || o_ram_rd_en) nb++;
    end
    chk("post_rst_quiet", 64'(nb), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
